// File: rtl/rv_instr_encoder.sv
// RV32I instruction encoder: turns field-level requests into 32-bit words and
// queues each legal word with its address in a 2-entry in-order FIFO.
module rv_instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op_type,
    input  logic [3:0]  operators,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instrCode,
    output logic [31:0] instrAddr,
    output logic        err,
    output logic [15:0] count
);

    typedef enum logic [3:0] {
        OP_R  = 4'd0,
        OP_I  = 4'd1,
        OP_L  = 4'd2,
        OP_S  = 4'd3,
        OP_B  = 4'd4,
        OP_LU = 4'd5,
        OP_AU = 4'd6,
        OP_J  = 4'd7,
        OP_JL = 4'd8
    } op_e;

    logic [2:0]  func3;
    logic        fits_12;
    logic        fits_b;
    logic        fits_j;
    logic        legal;
    logic [31:0] code;

    assign func3   = operators[2:0];
    // Sign-extension checks: upper bits must all equal the field's sign bit.
    assign fits_12 = (imm[31:11] == {21{imm[11]}});
    assign fits_b  = (imm[31:12] == {20{imm[12]}}) && !imm[0];
    assign fits_j  = (imm[31:20] == {12{imm[20]}}) && !imm[0];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        legal = 1'b1;
        code  = '0;
        case (op_e'(op_type))
            OP_R: code = {1'b0, operators[3], 5'b0, rs2, rs1, func3, rd, 7'b0110011};
            OP_I: begin
                if (func3 == 3'b001 || func3 == 3'b101) begin
                    code  = {1'b0, operators[3] & (func3 == 3'b101), 5'b0, imm[4:0],
                             rs1, func3, rd, 7'b0010011};
                    legal = (imm[31:5] == 27'd0);
                end else begin
                    code  = {imm[11:0], rs1, func3, rd, 7'b0010011};
                    legal = fits_12;
                end
            end
            OP_L: begin
                code  = {imm[11:0], rs1, func3, rd, 7'b0000011};
                legal = fits_12 && !(func3 == 3'b011 || func3 == 3'b110 || func3 == 3'b111);
            end
            OP_S: begin
                code  = {imm[11:5], rs2, rs1, func3, imm[4:0], 7'b0100011};
                legal = fits_12 && (func3 <= 3'b010);
            end
            OP_B: begin
                code  = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], 7'b1100011};
                legal = fits_b && !(func3 == 3'b010 || func3 == 3'b011);
            end
            OP_LU: code = {imm[31:12], rd, 7'b0110111};
            OP_AU: code = {imm[31:12], rd, 7'b0010111};
            OP_J: begin
                code  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
                legal = fits_j;
            end
            OP_JL: begin
                code  = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
                legal = fits_12;
            end
            default: legal = 1'b0;
        endcase
    end

    logic [31:0] mem_code_q [2];
    logic [31:0] mem_addr_q [2];
    logic [1:0]  occ_q,    occ_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [31:0] pc_q,     pc_d;
    logic [15:0] count_q,  count_d;
    logic        err_q,    err_d;
    logic        accept;
    logic        deliver;
    logic        push;

    assign in_ready  = (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;
    assign push      = accept && legal;
    assign instrCode = mem_code_q[rd_ptr_q];
    assign instrAddr = mem_addr_q[rd_ptr_q];
    assign err       = err_q;
    assign count     = count_q;

    always_comb begin
        occ_d    = occ_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        pc_d     = pc_q;
        count_d  = count_q;
        err_d    = err_q;
        if (clear) begin
            occ_d    = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            pc_d     = BASE_ADDR;
            count_d  = 16'd0;
            err_d    = 1'b0;
        end else begin
            if (deliver) rd_ptr_d = ~rd_ptr_q;
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
                pc_d     = pc_q + 32'd4;
                count_d  = count_q + 16'd1;
            end else if (accept) begin
                err_d = 1'b1;
            end
            occ_d = occ_q + 2'(push) - 2'(deliver);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            occ_q    <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            pc_q     <= BASE_ADDR;
            count_q  <= 16'd0;
            err_q    <= 1'b0;
        end else begin
            occ_q    <= occ_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the storage is reset only because the head is visible on instrCode/instrAddr right after reset.
            for (int i = 0; i < 2; i++) begin
                mem_code_q[i] <= '0;
                mem_addr_q[i] <= BASE_ADDR;
            end
        end else if (push && !clear) begin
            mem_code_q[wr_ptr_q] <= code;
            mem_addr_q[wr_ptr_q] <= pc_q;
        end
    end

endmodule

// File: doc/rv_instr_encoder.md
RV_INSTR_ENCODER -- requirements
Module: rv_instr_encoder

Interface
REQ-001 Parameter: BASE_ADDR, 32'h0000_0000, address assigned to the first encoded instruction after reset or clear.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 clear  input  1  synchronous flush of FIFO, address, count and err.
REQ-005 in_valid  input  1  request fields valid.
REQ-006 in_ready  output  1  encoder can accept a request.
REQ-007 op_type  input  4  0=R 1=I 2=L 3=S 4=B 5=LU 6=AU 7=J 8=JL; 9-15 illegal.
REQ-008 operators  input  4  {func7[5], func3}.
REQ-009 rd, rs1, rs2  input  5 each  register indices.
REQ-010 imm  input  32  signed byte immediate; LU/AU use imm[31:12] as the upper field.
REQ-011 out_valid  output  1  FIFO head valid.
REQ-012 out_ready  input  1  consumer accepts head.
REQ-013 instrCode  output  32  encoded RV32I word at FIFO head.
REQ-014 instrAddr  output  32  address tagged to FIFO head.
REQ-015 err  output  1  sticky illegal-request flag.
REQ-016 count  output  16  number of legal requests accepted.

Function
REQ-017 Accept occurs on a clock edge where in_valid && in_ready; deliver occurs on an edge where out_valid && out_ready.
REQ-018 Opcodes: R 0110011, I 0010011, L 0000011, S 0100011, B 1100011, LU 0110111, AU 0010111, J 1101111, JL 1100111.
REQ-019 R: {1'b0, operators[3], 5'b0, rs2, rs1, operators[2:0], rd, opcode}.
REQ-020 I with func3 001/101 (shift): {1'b0, operators[3]&func3==101, 5'b0, imm[4:0], rs1, func3, rd, opcode}; imm[31:5] nonzero is illegal; otherwise I: {imm[11:0], rs1, func3, rd, opcode}.
REQ-021 L: {imm[11:0], rs1, func3, rd, opcode}; S: {imm[11:5], rs2, rs1, func3, imm[4:0], opcode}; JL: {imm[11:0], rs1, 3'b000, rd, opcode}.
REQ-022 B: {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode}; J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}; LU/AU: {imm[31:12], rd, opcode}.
REQ-023 Illegal: op_type>8; I/L/S/JL imm outside [-2048,2047]; B imm outside [-4096,4094] or imm[0]=1; J imm outside [-1048576,1048574] or imm[0]=1; L func3 in {011,110,111}; S func3>010; B func3 in {010,011}.
REQ-024 Accepted illegal request: handshake completes, nothing enqueued, err set to 1, address and count unchanged.
REQ-025 Accepted legal request: pushed into 2-entry FIFO with current address; address += 4 (wraps modulo 2^32); count += 1 (wraps 0xFFFF->0).
REQ-026 Latency: request accepted at edge N appears at FIFO head no earlier than after edge N; out_valid is high in the cycle following edge N when the FIFO was empty.
REQ-027 in_ready = (FIFO occupancy < 2), derived from registered occupancy only; no same-cycle bypass when full.
REQ-028 Simultaneous accept and deliver with occupancy 1: occupancy stays 1, new entry becomes head next cycle.
REQ-029 FIFO strictly in-order; instrCode/instrAddr hold stable while out_valid && !out_ready.
REQ-030 clear takes priority over simultaneous accept and deliver: FIFO emptied, address=BASE_ADDR, count=0, err=0; the accepted request is discarded.

Reset
REQ-031 reset asserted: out_valid=0, in_ready=1 on deassertion, instrCode=0, instrAddr=BASE_ADDR, err=0, count=0, FIFO empty; effective immediately, mid-transfer data is lost.

Verification
REQ-032 addi x1,x0,5 (op_type=1, operators=0000, rd=1, imm=5) -> instrCode=0x00500093, instrAddr=0x0, count=1.
REQ-033 sub x3,x1,x2 (op_type=0, operators=1000) -> 0x402081B3; srai x5,x6,3 (op_type=1, operators=1101) -> 0x40335293.
REQ-034 jal x1,8 (op_type=7, rd=1, imm=8) -> 0x008000EF.
REQ-035 beq with imm=3 -> no out_valid, err=1, count unchanged; next legal request receives the unadvanced address.
REQ-036 out_ready=0, three legal requests -> in_ready low after two accepts; raising out_ready delivers addresses 0x0, 0x4, 0x8 in order.
REQ-037 clear asserted with two entries queued and in_valid high -> next cycle out_valid=0, count=0, err=0, next accepted request at BASE_ADDR.
